// File: rtl/decode_skid_ctrl_if.sv
// Fetch-side and dispatch-side handshake bundle for the decode skid controller.
// master = environment (fetch producer + dispatch consumer), slave = controller.
interface decode_skid_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 flush;
    logic                 fetch_valid;
    logic                 fetch_ready;
    logic [31:0]          fetch_instr;
    logic [PC_WIDTH-1:0]  fetch_pc;
    logic                 dec_valid;
    logic                 dec_ready;
    logic [31:0]          dec_instr;
    logic [PC_WIDTH-1:0]  dec_pc;
    logic [2:0]           dec_type;     // r=0 i=1 s=2 b=3 u=4 j=5
    logic [31:0]          dec_imm;
    logic                 dec_illegal;
    logic [CNT_WIDTH-1:0] dec_count;

    modport master (
        output flush, fetch_valid, fetch_instr, fetch_pc, dec_ready,
        input  fetch_ready, dec_valid, dec_instr, dec_pc, dec_type,
               dec_imm, dec_illegal, dec_count
    );

    modport slave (
        input  flush, fetch_valid, fetch_instr, fetch_pc, dec_ready,
        output fetch_ready, dec_valid, dec_instr, dec_pc, dec_type,
               dec_imm, dec_illegal, dec_count
    );
endinterface

// File: rtl/decode_skid_ctrl.sv
// Decode stage: classifies RV32I opcodes, builds immediates, buffers entries in a 2-deep skid.
// Latency 1 cycle fetch->dec; fetch_ready is registered and never depends on dec_ready.
module decode_imm_gen (
    input  logic [31:0] instr,
    input  logic [2:0]  typ,
    output logic [31:0] imm
);
    localparam logic [2:0] TYPE_I = 3'd1, TYPE_S = 3'd2, TYPE_B = 3'd3,
                           TYPE_U = 3'd4, TYPE_J = 3'd5;

    always_comb begin
        imm = '0;
        case (typ)
            TYPE_I:  imm = {{20{instr[31]}}, instr[31:20]};
            TYPE_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            TYPE_U:  imm = {instr[31:12], 12'b0};
            TYPE_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

module decode_skid_ctrl #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    decode_skid_ctrl_if.slave        bus
);
    typedef enum logic [2:0] {
        T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5
    } instr_type_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        instr_type_t         typ;
        logic [31:0]         imm;
        logic                illegal;
    } entry_t;

    state_t               state;
    entry_t               head, skid, in_entry;
    instr_type_t          in_type;
    logic                 in_illegal;
    logic [31:0]          in_imm;
    logic                 ready_q, valid_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 push, pop;

    always_comb begin
        in_type    = T_R;
        in_illegal = 1'b0;
        case (bus.fetch_instr[6:0])
            7'b0110111, 7'b0010111:                         in_type = T_U;
            7'b1101111:                                     in_type = T_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: in_type = T_I;
            7'b0100011:                                     in_type = T_S;
            7'b1100011:                                     in_type = T_B;
            7'b0110011:                                     in_type = T_R;
            default:                                        in_illegal = 1'b1;
        endcase
    end

    decode_imm_gen u_imm_gen (
        .instr (bus.fetch_instr),
        .typ   (in_type),
        .imm   (in_imm)
    );

    assign in_entry = '{instr: bus.fetch_instr, pc: bus.fetch_pc, typ: in_type,
                        imm: in_imm, illegal: in_illegal};

    assign push = bus.fetch_valid & ready_q;
    assign pop  = valid_q & bus.dec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            // Squash wins over any same-cycle push or pop; the count is kept.
            state   <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            if (pop) cnt_q <= cnt_q + CNT_WIDTH'(1);
            unique case (state)
                EMPTY: if (push) begin
                    head    <= in_entry;
                    state   <= ONE;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                end
                ONE: if (push && !pop) begin
                    skid    <= in_entry;
                    state   <= TWO;
                    ready_q <= 1'b0;
                end else if (push) begin
                    head    <= in_entry;
                end else if (pop) begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
                TWO: if (pop) begin
                    head    <= skid;
                    state   <= ONE;
                    ready_q <= 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.fetch_ready = ready_q;
    assign bus.dec_valid   = valid_q;
    assign bus.dec_instr   = head.instr;
    assign bus.dec_pc      = head.pc;
    assign bus.dec_type    = head.typ;
    assign bus.dec_imm     = head.imm;
    assign bus.dec_illegal = head.illegal;
    assign bus.dec_count   = cnt_q;
endmodule

// File: tb/tb_decode_skid_ctrl.sv
// Directed bench for decode_skid_ctrl: hand-computed decode results, skid ordering, flush, reset, wrap.
module tb_decode_skid_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [2:0] TR = 3'd0, TI = 3'd1, TS = 3'd2, TB = 3'd3, TU = 3'd4, TJ = 3'd5;

    always #5 clk = ~clk;

    decode_skid_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();

    decode_skid_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
        bus.fetch_valid = v;
        bus.fetch_instr = ins;
        bus.fetch_pc    = pc;
        bus.dec_ready   = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [2:0] t, input logic [31:0] imm,
                            input logic [31:0] ins);
        chk({tag, "_valid"}, bus.dec_valid, 1'b1);
        chk({tag, "_type"},  bus.dec_type,  t);
        chk({tag, "_imm"},   bus.dec_imm,   imm);
        chk({tag, "_instr"}, bus.dec_instr, ins);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        chk("rst_valid", bus.dec_valid, 1'b0);
        chk("rst_ready", bus.fetch_ready, 1'b1);
        chk("rst_count", bus.dec_count, 32'd0);
        chk("rst_type",  bus.dec_type, TR);
        chk("rst_ill",   bus.dec_illegal, 1'b0);
        chk("rst_instr", bus.dec_instr, 32'd0);
        rst = 1'b0;
        step();

        // 1: addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h1000, 1'b1);
        step();
        chk_head("t1", TI, 32'hFFFFFFFF, 32'hFFF00093);
        chk("t1_pc", bus.dec_pc, 32'h1000);
        chk("t1_cnt0", bus.dec_count, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("t1_cnt1", bus.dec_count, 32'd1);
        chk("t1_empty", bus.dec_valid, 1'b0);

        // 2: lui then sw with dispatch stalled -> fills skid
        drive(1'b1, 32'h12345037, 32'h1004, 1'b0);
        step();
        chk("t2_rdy_one", bus.fetch_ready, 1'b1);
        drive(1'b1, 32'h0020A423, 32'h1008, 1'b0);
        step();
        chk("t2_rdy_two", bus.fetch_ready, 1'b0);
        chk_head("t2_lui", TU, 32'h12345000, 32'h12345037);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk_head("t2_sw", TS, 32'h00000008, 32'h0020A423);
        chk("t2_sw_pc", bus.dec_pc, 32'h1008);
        chk("t2_rdy_back", bus.fetch_ready, 1'b1);
        chk("t2_cnt", bus.dec_count, 32'd2);
        step();
        chk("t2_empty", bus.dec_valid, 1'b0);
        chk("t2_cnt2", bus.dec_count, 32'd3);

        // 3: back-to-back beq / jal / beq, no bubbles
        drive(1'b1, 32'hFE000EE3, 32'h2000, 1'b1);
        step();
        chk_head("t3_beq", TB, 32'hFFFFFFFC, 32'hFE000EE3);
        drive(1'b1, 32'h0080006F, 32'h2004, 1'b1);
        step();
        chk_head("t3_jal", TJ, 32'h00000008, 32'h0080006F);
        chk("t3_cnt_a", bus.dec_count, 32'd4);
        drive(1'b1, 32'hFE000EE3, 32'h2008, 1'b1);
        step();
        chk_head("t3_beq2", TB, 32'hFFFFFFFC, 32'hFE000EE3);
        chk("t3_rdy", bus.fetch_ready, 1'b1);
        chk("t3_cnt_b", bus.dec_count, 32'd5);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        chk("t3_empty", bus.dec_valid, 1'b0);
        chk("t3_cnt_c", bus.dec_count, 32'd6);

        // 4: illegal opcode
        drive(1'b1, 32'h0000007F, 32'h3000, 1'b0);
        step();
        chk_head("t4_bad", TR, 32'h0, 32'h0000007F);
        chk("t4_ill", bus.dec_illegal, 1'b1);

        // 5: fill to TWO, then flush with dispatch ready
        drive(1'b1, 32'h12345037, 32'h3004, 1'b0);
        step();
        chk("t5_two", bus.fetch_ready, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t5_valid", bus.dec_valid, 1'b0);
        chk("t5_rdy", bus.fetch_ready, 1'b1);
        chk("t5_cnt", bus.dec_count, 32'd6);

        // 6: async reset in ONE, between clock edges
        drive(1'b1, 32'hFFF00093, 32'h4000, 1'b0);
        step();
        chk("t6_one", bus.dec_valid, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", bus.dec_valid, 1'b0);
        chk("t6_rdy", bus.fetch_ready, 1'b1);
        chk("t6_cnt", bus.dec_count, 32'd0);
        chk("t6_instr", bus.dec_instr, 32'd0);
        chk("t6_pc", bus.dec_pc, 32'd0);
        chk("t6_imm", bus.dec_imm, 32'd0);
        chk("t6_type", bus.dec_type, TR);
        #1 rst = 1'b0;
        drive(1'b1, 32'h0020A423, 32'h4004, 1'b0);
        step();
        chk_head("t6_first", TS, 32'h00000008, 32'h0020A423);

        // 7: counter wrap from all-ones
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        bus.dec_ready = 1'b1;
        step();
        chk("t7_wrap", bus.dec_count, 32'd0);
        chk("t7_empty", bus.dec_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
